// File: rtl/stack_ctrl_pkg.sv
// Shared types and helpers for the hardware stack controller.
package stack_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StRdWait = 2'd2,
    StResp   = 2'd3
  } state_e;

  // SP value of an empty full-descending stack of 2**aw words.
  function automatic int unsigned sp_empty_val(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/stack_ptr_reg.sv
// Stack pointer register with increment/decrement and empty/full flags.
module stack_ptr_reg
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned AddrW = 10
) (
  input  logic           clk,
  input  logic           async_reset,
  input  logic           inc,
  input  logic           dec,
  output logic [AddrW:0] sp,
  output logic           empty,
  output logic           full
);

  localparam int unsigned SpW = AddrW + 1;
  localparam logic [AddrW:0] SpEmpty = SpW'(sp_empty_val(AddrW));

  logic [AddrW:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (inc) begin
      sp_d = sp_q + SpW'(1);
    end else if (dec) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      sp_q <= SpEmpty;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign sp    = sp_q;
  assign empty = (sp_q == SpEmpty);
  assign full  = (sp_q == '0);

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop controller between the core and DMEM; owns the full-descending stack pointer.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned BITS            = 32,
  parameter int unsigned ADDR_WIDTH_DMEM = 10
) (
  input  logic                       clk,
  input  logic                       async_reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_push,
  input  logic [BITS-1:0]            req_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [BITS-1:0]            resp_data,
  output logic                       resp_err,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_WIDTH_DMEM-1:0] mem_addr,
  output logic [BITS-1:0]            mem_wdata,
  input  logic [BITS-1:0]            mem_rdata,
  output logic [ADDR_WIDTH_DMEM:0]   sp,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = ADDR_WIDTH_DMEM;

  state_e          state_q, state_d;
  logic            push_q, push_d;
  logic [BITS-1:0] resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic            sp_inc, sp_dec;

  stack_ptr_reg #(
    .AddrW (AW)
  ) u_sp (
    .clk         (clk),
    .async_reset (async_reset),
    .inc         (sp_inc),
    .dec         (sp_dec),
    .sp          (sp),
    .empty       (empty),
    .full        (full)
  );

  always_comb begin
    state_d     = state_q;
    push_d      = push_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          push_d = req_push;
          if (req_push ? full : empty) begin
            resp_err_d = 1'b1;
            state_d    = StResp;
          end else begin
            // DMEM port is loaded here so it is driven from flops during ACCESS.
            mem_en_d    = 1'b1;
            mem_we_d    = req_push;
            mem_addr_d  = req_push ? (sp[AW-1:0] - AW'(1)) : sp[AW-1:0];
            mem_wdata_d = req_push ? req_data : '0;
            state_d     = StAccess;
          end
        end
      end
      StAccess: begin
        if (push_q) begin
          sp_dec  = 1'b1;
          state_d = StResp;
        end else begin
          sp_inc  = 1'b1;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        resp_data_d = mem_rdata;
        state_d     = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q     <= StIdle;
      push_q      <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      push_q      <= push_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: queue-based stack model, 1-cycle-latency DMEM model, directed vectors.
module tb_stack_ctrl;

  localparam int unsigned BITS  = 32;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic            clk;
  logic            async_reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_push;
  logic [BITS-1:0] req_data;
  logic            resp_valid;
  logic            resp_ready;
  logic [BITS-1:0] resp_data;
  logic            resp_err;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [BITS-1:0] mem_wdata;
  logic [BITS-1:0] mem_rdata;
  logic [AW:0]     sp;
  logic            empty;
  logic            full;

  stack_ctrl #(
    .BITS            (BITS),
    .ADDR_WIDTH_DMEM (AW)
  ) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_push    (req_push),
    .req_data    (req_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .sp          (sp),
    .empty       (empty),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMEM: synchronous write, registered read (1-cycle latency).
  logic [BITS-1:0] dmem [DEPTH];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= dmem[mem_addr];
    end
  end

  int          checks;
  int          errors;
  logic [31:0] model_q[$];
  bit          mon_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whenever the controller is idle, its visible state must match the stack model.
  always @(negedge clk) begin
    if (mon_en && !async_reset && req_ready) begin
      check("idle_sp", 64'(sp), 64'(DEPTH - model_q.size()));
      check("idle_empty", 64'(empty), 64'(model_q.size() == 0));
      check("idle_full", 64'(full), 64'(model_q.size() == DEPTH));
      check("idle_resp_valid", 64'(resp_valid), 64'd0);
      check("idle_mem_en", 64'(mem_en), 64'd0);
    end
  end

  task automatic do_req(input bit push, input logic [31:0] data, input int hold,
                        output logic [31:0] got);
    bit          err;
    logic [31:0] exp_data;
    int          exp_lat, exp_addr, exp_sp_after, lat, n, size;
    size         = model_q.size();
    err          = push ? (size == DEPTH) : (size == 0);
    exp_data     = (!push && !err) ? model_q[$] : 32'd0;
    exp_lat      = err ? 1 : (push ? 2 : 3);
    exp_addr     = push ? (DEPTH - size - 1) : (DEPTH - size);
    exp_sp_after = err ? (DEPTH - size) : (push ? DEPTH - size - 1 : DEPTH - size + 1);
    got = '0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_wait", 64'(req_ready), 64'd1);
    resp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_push  = push;
    req_data  = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = '0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("access_mem_en", 64'(mem_en), 64'(!err));
        if (!err) begin
          check("access_mem_we", 64'(mem_we), 64'(push));
          check("access_mem_addr", 64'(mem_addr), 64'(exp_addr));
          if (push) check("access_mem_wdata", 64'(mem_wdata), 64'(data));
        end
      end
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("resp_err", 64'(resp_err), 64'(err));
    check("resp_data", 64'(resp_data), 64'(exp_data));
    got = resp_data;
    for (int i = 0; i < hold; i++) begin
      req_valid = (i % 2 == 0);
      req_push  = 1'b0;
      @(negedge clk);
      check("hold_resp_valid", 64'(resp_valid), 64'd1);
      check("hold_resp_data", 64'(resp_data), 64'(exp_data));
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_sp", 64'(sp), 64'(exp_sp_after));
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("resp_clear", 64'(resp_valid), 64'd0);
    check("resp_err_clear", 64'(resp_err), 64'd0);
    check("ready_back", 64'(req_ready), 64'd1);
    if (!err) begin
      if (push) model_q.push_back(data);
      else      void'(model_q.pop_back());
    end
  endtask

  logic [31:0] got;
  logic [31:0] pop_exp [4];

  initial begin
    checks      = 0;
    errors      = 0;
    mon_en      = 1'b0;
    async_reset = 1'b1;
    req_valid   = 1'b0;
    req_push    = 1'b0;
    req_data    = '0;
    resp_ready  = 1'b1;
    #12;
    check("rst_sp", 64'(sp), 64'd4);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    @(negedge clk);
    async_reset = 1'b0;
    mon_en      = 1'b1;

    do_req(1'b1, 32'hA5A5_0001, 0, got);
    check("push1_sp", 64'(sp), 64'd3);
    do_req(1'b0, '0, 0, got);
    check("pop1_data", 64'(got), 64'hA5A5_0001);

    for (int i = 1; i <= 4; i++) do_req(1'b1, 32'(i * 'h11), 0, got);
    check("fill_full", 64'(full), 64'd1);
    check("fill_sp", 64'(sp), 64'd0);
    do_req(1'b1, 32'h55, 0, got);
    check("ovf_sp", 64'(sp), 64'd0);

    pop_exp[0] = 32'h44;
    pop_exp[1] = 32'h33;
    pop_exp[2] = 32'h22;
    pop_exp[3] = 32'h11;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, '0, 0, got);
      check("drain_data", 64'(got), 64'(pop_exp[i]));
    end
    check("drain_empty", 64'(empty), 64'd1);
    do_req(1'b0, '0, 0, got);
    check("udf_data", 64'(got), 64'd0);

    do_req(1'b1, 32'h5A, 0, got);
    do_req(1'b0, '0, 5, got);
    check("hold_pop_data", 64'(got), 64'h5A);

    // Reset during the ACCESS cycle of a pop.
    do_req(1'b1, 32'h66, 0, got);
    @(negedge clk);
    req_valid = 1'b1;
    req_push  = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    check("mid_pop_mem_en", 64'(mem_en), 64'd1);
    check("mid_pop_mem_we", 64'(mem_we), 64'd0);
    async_reset = 1'b1;
    mon_en      = 1'b0;
    model_q.delete();
    #1;
    check("arst_mem_en", 64'(mem_en), 64'd0);
    check("arst_sp", 64'(sp), 64'd4);
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_empty", 64'(empty), 64'd1);
    @(negedge clk);
    @(negedge clk);
    async_reset = 1'b0;
    mon_en      = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_no_resp", 64'(resp_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
